// File: rtl/dsram_bridge_pkg.sv
// Shared state encoding, access-size and AXI response constants for the
// uncached data-SRAM to AXI bridge.
package dsram_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        DONE    = 3'd5
    } dsb_state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [7:0] LEN_SINGLE = 8'd0;

    // The core never issues size 3; treat it as a word so AXI sees a legal size.
    function automatic logic [1:0] coerce_size(input logic [1:0] size);
        return (size == 2'd3) ? SZ_WORD : size;
    endfunction

    function automatic logic resp_is_error(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/dsram_uncached_bridge.sv
// Converts one uncached load/store from the memory stage into a single-beat
// AXI4 transaction and answers with a one-cycle data_ok pulse.
module dsram_uncached_bridge
    import dsram_bridge_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        flush,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic        bus_err,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    dsb_state_t  state;
    dsb_state_t  state_next;

    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        wr_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        aw_done;
    logic        w_done;
    logic        cancel;
    logic        bus_err_q;

    logic        accept;
    logic        r_take;
    logic        b_take;

    assign accept = (state == IDLE) && data_sram_req && !flush;
    assign r_take = (state == RD_DATA) && rvalid;
    assign b_take = (state == WR_RESP) && bvalid;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus all handshake outputs; every AXI valid/ready is a pure
    // state/flag decode so no AXI input reaches an AXI output combinationally.
    always_comb begin
        state_next        = state;
        arvalid           = 1'b0;
        rready            = 1'b0;
        awvalid           = 1'b0;
        wvalid            = 1'b0;
        bready            = 1'b0;
        data_sram_data_ok = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = data_sram_wr ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    state_next = DONE;
                end
            end
            WR_REQ: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || awready) && (w_done || wready)) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                data_sram_data_ok = !cancel;
                state_next        = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            addr_q  <= 32'd0;
            size_q  <= SZ_BYTE;
            wr_q    <= 1'b0;
            wstrb_q <= 4'd0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            addr_q  <= data_sram_addr;
            size_q  <= coerce_size(data_sram_size);
            wr_q    <= data_sram_wr;
            wstrb_q <= data_sram_wstrb;
            wdata_q <= data_sram_wdata;
        end
    end

    // AW and W may complete in either order; each flag keeps its channel
    // from issuing a second beat while the other is still waiting.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state == WR_REQ) begin
            if (awvalid && awready) begin
                aw_done <= 1'b1;
            end
            if (wvalid && wready) begin
                w_done <= 1'b1;
            end
        end else begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end
    end

    // A flushed access still finishes on AXI, but its result is dropped.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            cancel <= 1'b0;
        end else if (state == DONE) begin
            cancel <= 1'b0;
        end else if (flush && (state != IDLE)) begin
            cancel <= 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            rdata_q   <= 32'd0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= (r_take && resp_is_error(rresp)) ||
                         (b_take && resp_is_error(bresp));
            if (r_take && !wr_q && !cancel && !flush) begin
                rdata_q <= rdata;
            end
        end
    end

    assign data_sram_rdata = rdata_q;
    assign bus_err         = bus_err_q;

    assign arid    = AXI_ID;
    assign araddr  = addr_q;
    assign arlen   = LEN_SINGLE;
    assign arsize  = {1'b0, size_q};
    assign arburst = BURST_INCR;

    assign awid    = AXI_ID;
    assign awaddr  = addr_q;
    assign awlen   = LEN_SINGLE;
    assign awsize  = {1'b0, size_q};
    assign awburst = BURST_INCR;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;

endmodule

// File: tb/tb_dsram_uncached_bridge.sv
// Self-checking bench for dsram_uncached_bridge: a cycle-level AXI slave with
// programmable wait states and a timing/data model derived from the access rules.
module tb_dsram_uncached_bridge;
    import dsram_bridge_pkg::*;

    localparam logic [3:0] TB_ID = 4'd5;

    logic        Clk;
    logic        reset;
    logic        flush;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        bus_err;
    logic [3:0]  arid, awid;
    logic [31:0] araddr, awaddr;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    dsram_uncached_bridge #(.AXI_ID(TB_ID)) dut (
        .Clk(Clk), .reset(reset), .flush(flush),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .bus_err(bus_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_rdata;

    int ok_count, ok_cycle, err_count, err_cycle;
    int ar_hs, r_hs, aw_hs, w_hs, b_hs, bready_cycles;
    logic [31:0] seen_addr, seen_wdata, rdata_at_ok;
    logic [2:0]  seen_size;
    logic [3:0]  seen_strb, seen_id;
    logic [7:0]  seen_len;
    logic [1:0]  seen_burst;
    logic        seen_wlast;
    bit          timed_out;

    // Drives one access from a negedge and plays the slave. For loads a_wait/d_wait
    // are AR/R wait states; for stores they are AW/W wait states and b_wait is B.
    task automatic run_access(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                              input logic [3:0] strb, input logic [31:0] wd, input logic [31:0] rd,
                              input logic [1:0] resp, input int a_wait, input int d_wait,
                              input int b_wait, input int flush_at);
        int a_seen = 0;
        int w_seen = 0;
        int resp_cnt = 0;
        int done_cycle = -1;
        bit a_done = 0;
        bit wd_done = 0;
        bit r_done = 0;
        bit finished = 0;
        ok_count = 0; ok_cycle = -1; err_count = 0; err_cycle = -1;
        ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0; bready_cycles = 0;
        seen_addr = 'x; seen_wdata = 'x; seen_size = 'x; seen_strb = 'x; seen_id = 'x;
        seen_len = 'x; seen_burst = 'x; seen_wlast = 1'b0; rdata_at_ok = 'x;
        data_sram_req = 1'b1; data_sram_wr = wr; data_sram_size = size;
        data_sram_addr = addr; data_sram_wstrb = strb; data_sram_wdata = wd;
        for (int c = 0; c < 100 && !finished; c++) begin
            if (c > 0) begin
                @(posedge Clk);
                @(negedge Clk);
            end
            if (data_sram_data_ok) begin ok_count++; ok_cycle = c; rdata_at_ok = data_sram_rdata; end
            if (bus_err) begin err_count++; err_cycle = c; end
            if (bready) bready_cycles++;
            flush = (c == flush_at);
            if (c == flush_at) data_sram_req = 1'b0;
            if (!wr) begin
                rvalid = a_done && !r_done && (resp_cnt >= d_wait);
                rdata  = rvalid ? rd : $urandom;
                rresp  = resp;
                if (a_done && !r_done) resp_cnt++;
                if (rvalid && rready) begin r_hs++; r_done = 1; done_cycle = c + 1; end
                arready = arvalid && (a_seen >= a_wait);
                if (arvalid && arready) begin
                    ar_hs++; a_done = 1;
                    seen_addr = araddr; seen_size = arsize; seen_id = arid;
                    seen_len = arlen; seen_burst = arburst;
                end
                if (arvalid) a_seen++;
            end else begin
                bvalid = a_done && wd_done && !r_done && (resp_cnt >= b_wait);
                bresp  = resp;
                if (a_done && wd_done && !r_done) resp_cnt++;
                if (bvalid && bready) begin b_hs++; r_done = 1; done_cycle = c + 1; end
                awready = awvalid && (a_seen >= a_wait);
                wready  = wvalid && (w_seen >= d_wait);
                if (awvalid && awready) begin
                    aw_hs++; a_done = 1;
                    seen_addr = awaddr; seen_size = awsize; seen_id = awid;
                    seen_len = awlen; seen_burst = awburst;
                end
                if (wvalid && wready) begin
                    w_hs++; wd_done = 1;
                    seen_wdata = wdata; seen_strb = wstrb; seen_wlast = wlast;
                end
                if (awvalid) a_seen++;
                if (wvalid) w_seen++;
            end
            if (done_cycle >= 0 && c == done_cycle + 1) data_sram_req = 1'b0;
            if (done_cycle >= 0 && c == done_cycle + 3) finished = 1;
        end
        timed_out = !finished;
        data_sram_req = 1'b0; flush = 1'b0;
        arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge Clk);
        checks++;
        if ({arvalid, rready, awvalid, wvalid, bready, data_sram_data_ok, bus_err} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_handshakes: got %b, expected 0000000",
                     {arvalid, rready, awvalid, wvalid, bready, data_sram_data_ok, bus_err});
        end
        checks++;
        if (data_sram_rdata !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_rdata: got %h, expected 0", data_sram_rdata);
        end
        checks++;
        if (araddr !== 32'd0 || wdata !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_capture: got addr %h data %h, expected 0", araddr, wdata);
        end
        reset = 1'b0;
        model_rdata = 32'd0;
        @(negedge Clk);
    endtask

    task automatic test_load_basic();
        run_access(1'b0, SZ_WORD, 32'hBFC0_0004, 4'h0, 32'h0, 32'h1234_5678, RESP_OKAY, 0, 0, 0, -1);
        model_rdata = 32'h1234_5678;
        checks++;
        if (timed_out || ok_count !== 1 || ok_cycle !== 3) begin
            errors++; $display("[TB] FAIL load_latency: got ok %0d at cycle %0d, expected 1 at 3", ok_count, ok_cycle);
        end
        checks++;
        if (rdata_at_ok !== 32'h1234_5678) begin
            errors++; $display("[TB] FAIL load_rdata: got %h, expected 12345678", rdata_at_ok);
        end
        checks++;
        if (seen_addr !== 32'hBFC0_0004 || seen_size !== 3'd2) begin
            errors++; $display("[TB] FAIL load_ar: got %h/%0d, expected bfc00004/2", seen_addr, seen_size);
        end
        checks++;
        if (seen_id !== TB_ID || seen_len !== 8'd0 || seen_burst !== BURST_INCR) begin
            errors++; $display("[TB] FAIL load_ar_fields: got id %0d len %0d burst %0d, expected %0d 0 1",
                               seen_id, seen_len, seen_burst, TB_ID);
        end
    endtask

    task automatic test_store_byte();
        run_access(1'b1, SZ_BYTE, 32'hBFD0_0003, 4'b1000, 32'hAB00_0000, 32'h0, RESP_OKAY, 0, 2, 1, -1);
        checks++;
        if (timed_out || aw_hs !== 1 || w_hs !== 1 || b_hs !== 1) begin
            errors++; $display("[TB] FAIL store_beats: got aw %0d w %0d b %0d, expected 1 1 1", aw_hs, w_hs, b_hs);
        end
        checks++;
        if (seen_wlast !== 1'b1 || seen_size !== 3'd0 || seen_addr !== 32'hBFD0_0003) begin
            errors++; $display("[TB] FAIL store_aw: got wlast %b size %0d addr %h, expected 1 0 bfd00003",
                               seen_wlast, seen_size, seen_addr);
        end
        checks++;
        if (seen_strb !== 4'b1000 || seen_wdata !== 32'hAB00_0000) begin
            errors++; $display("[TB] FAIL store_w: got %b/%h, expected 1000/ab000000", seen_strb, seen_wdata);
        end
        checks++;
        if (ok_count !== 1 || ok_cycle !== 6) begin
            errors++; $display("[TB] FAIL store_ok: got %0d at %0d, expected 1 at 6", ok_count, ok_cycle);
        end
        checks++;
        if (data_sram_rdata !== model_rdata) begin
            errors++; $display("[TB] FAIL store_rdata_held: got %h, expected %h", data_sram_rdata, model_rdata);
        end
    endtask

    task automatic test_store_orders();
        int aw_w[2] = '{3, 0};
        int b_w[2]  = '{0, 2};
        for (int i = 0; i < 2; i++) begin
            run_access(1'b1, SZ_WORD, 32'h8000_0100 + i * 4, 4'hF, 32'hC0DE_0000 + i, 32'h0,
                       RESP_OKAY, aw_w[i], 0, b_w[i], -1);
            checks++;
            if (timed_out || aw_hs !== 1 || w_hs !== 1 || b_hs !== 1) begin
                errors++; $display("[TB] FAIL order%0d_beats: got aw %0d w %0d b %0d, expected 1 1 1",
                                   i, aw_hs, w_hs, b_hs);
            end
            checks++;
            if (bready_cycles !== b_w[i] + 1) begin
                errors++; $display("[TB] FAIL order%0d_wr_resp: got %0d bready cycles, expected %0d",
                                   i, bready_cycles, b_w[i] + 1);
            end
            checks++;
            if (ok_count !== 1 || ok_cycle !== 3 + aw_w[i] + b_w[i]) begin
                errors++; $display("[TB] FAIL order%0d_ok: got %0d at %0d, expected 1 at %0d",
                                   i, ok_count, ok_cycle, 3 + aw_w[i] + b_w[i]);
            end
        end
    endtask

    task automatic test_flush_rd();
        run_access(1'b0, SZ_WORD, 32'hA000_0010, 4'h0, 32'h0, 32'hDEAD_BEEF, RESP_OKAY, 0, 5, 0, 3);
        checks++;
        if (timed_out || r_hs !== 1 || ok_count !== 0) begin
            errors++; $display("[TB] FAIL flush_cancel: got r %0d ok %0d, expected 1 0", r_hs, ok_count);
        end
        checks++;
        if (data_sram_rdata !== model_rdata) begin
            errors++; $display("[TB] FAIL flush_rdata: got %h, expected %h", data_sram_rdata, model_rdata);
        end
        run_access(1'b0, SZ_HALF, 32'hA000_0022, 4'h0, 32'h0, 32'h5555_AAAA, RESP_OKAY, 0, 0, 0, -1);
        model_rdata = 32'h5555_AAAA;
        checks++;
        if (ok_count !== 1 || ok_cycle !== 3 || rdata_at_ok !== model_rdata || seen_size !== 3'd1) begin
            errors++; $display("[TB] FAIL flush_next: got ok %0d at %0d data %h size %0d, expected 1 at 3 %h 1",
                               ok_count, ok_cycle, rdata_at_ok, seen_size, model_rdata);
        end
    endtask

    task automatic test_bus_err();
        run_access(1'b0, SZ_WORD, 32'h1F00_0000, 4'h0, 32'h0, 32'h0BAD_0BAD, RESP_SLVERR, 0, 0, 0, -1);
        model_rdata = 32'h0BAD_0BAD;
        checks++;
        if (err_count !== 1 || ok_count !== 1 || err_cycle !== 3 || ok_cycle !== 3) begin
            errors++; $display("[TB] FAIL rd_bus_err: got err %0d@%0d ok %0d@%0d, expected 1@3 1@3",
                               err_count, err_cycle, ok_count, ok_cycle);
        end
        run_access(1'b1, SZ_HALF, 32'h1F00_0002, 4'b1100, 32'h7777_0000, 32'h0, RESP_DECERR, 0, 0, 2, -1);
        checks++;
        if (err_count !== 1 || ok_count !== 1 || err_cycle !== 5 || ok_cycle !== 5) begin
            errors++; $display("[TB] FAIL wr_bus_err: got err %0d@%0d ok %0d@%0d, expected 1@5 1@5",
                               err_count, err_cycle, ok_count, ok_cycle);
        end
    endtask

    task automatic test_flush_idle();
        data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_size = SZ_WORD;
        data_sram_addr = 32'h0000_0040; flush = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        data_sram_req = 1'b0; flush = 1'b0;
        checks++;
        if (arvalid !== 1'b0 || awvalid !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_idle: got arvalid %b awvalid %b, expected 0 0", arvalid, awvalid);
        end
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_back_to_back();
        int first_ok = -1;
        int second_ok = -1;
        int ok_total = 0;
        int ars = 0;
        bit pend_r = 0;
        logic [31:0] vals[2] = '{32'h1111_2222, 32'h3333_4444};
        data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_size = SZ_WORD;
        data_sram_addr = 32'h1FC0_0000;
        for (int c = 0; c < 14; c++) begin
            if (c > 0) begin
                @(posedge Clk);
                @(negedge Clk);
            end
            if (data_sram_data_ok) begin
                ok_total++;
                if (first_ok < 0) first_ok = c; else second_ok = c;
            end
            if (c == 8) data_sram_req = 1'b0;
            rvalid = pend_r;
            rresp  = RESP_OKAY;
            rdata  = (ars >= 2) ? vals[1] : vals[0];
            if (rvalid && rready) pend_r = 0;
            arready = 1'b1;
            if (arvalid) begin ars++; pend_r = 1; end
        end
        arready = 1'b0; rvalid = 1'b0;
        model_rdata = vals[1];
        checks++;
        if (ok_total !== 2 || first_ok !== 3 || second_ok !== 7) begin
            errors++; $display("[TB] FAIL b2b_spacing: got %0d oks at %0d,%0d, expected 2 at 3,7",
                               ok_total, first_ok, second_ok);
        end
        checks++;
        if (ars !== 2 || data_sram_rdata !== vals[1]) begin
            errors++; $display("[TB] FAIL b2b_data: got %0d AR, rdata %h, expected 2, %h", ars, data_sram_rdata, vals[1]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            logic        wr   = 1'($urandom);
            logic [1:0]  size = 2'($urandom);
            logic [31:0] addr = $urandom;
            logic [3:0]  strb = 4'($urandom);
            logic [31:0] wd   = $urandom;
            logic [31:0] rd   = $urandom;
            logic [1:0]  resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : RESP_OKAY;
            int          aw   = $urandom_range(0, 3);
            int          dw   = $urandom_range(0, 3);
            int          bw   = $urandom_range(0, 3);
            int          exp_done = wr ? 3 + ((aw > dw) ? aw : dw) + bw : 3 + aw + dw;
            logic [2:0]  exp_size = {1'b0, (size == 2'd3) ? SZ_WORD : size};
            run_access(wr, size, addr, strb, wd, rd, resp, aw, dw, bw, -1);
            if (!wr) model_rdata = rd;
            checks++;
            if (timed_out || ok_count !== 1 || ok_cycle !== exp_done) begin
                errors++; $display("[TB] FAIL rand%0d_ok: got %0d at %0d, expected 1 at %0d",
                                   i, ok_count, ok_cycle, exp_done);
            end
            checks++;
            if (err_count !== ((resp != RESP_OKAY) ? 1 : 0) || (resp != RESP_OKAY && err_cycle !== exp_done)) begin
                errors++; $display("[TB] FAIL rand%0d_err: got %0d at %0d, resp %0d done %0d",
                                   i, err_count, err_cycle, resp, exp_done);
            end
            checks++;
            if (seen_addr !== addr || seen_size !== exp_size) begin
                errors++; $display("[TB] FAIL rand%0d_addr: got %h/%0d, expected %h/%0d",
                                   i, seen_addr, seen_size, addr, exp_size);
            end
            checks++;
            if (data_sram_rdata !== model_rdata) begin
                errors++; $display("[TB] FAIL rand%0d_rdata: got %h, expected %h", i, data_sram_rdata, model_rdata);
            end
            if (wr) begin
                checks++;
                if (aw_hs !== 1 || w_hs !== 1 || b_hs !== 1 || seen_strb !== strb || seen_wdata !== wd) begin
                    errors++; $display("[TB] FAIL rand%0d_store: got %0d%0d%0d %b %h, expected 111 %b %h",
                                       i, aw_hs, w_hs, b_hs, seen_strb, seen_wdata, strb, wd);
                end
            end else begin
                checks++;
                if (ar_hs !== 1 || r_hs !== 1) begin
                    errors++; $display("[TB] FAIL rand%0d_load: got ar %0d r %0d, expected 1 1", i, ar_hs, r_hs);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_size = SZ_WORD;
        data_sram_addr = 32'h2000_0000; data_sram_wstrb = 4'hF; data_sram_wdata = 32'h1357_9BDF;
        awready = 1'b0; wready = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1) begin
            errors++; $display("[TB] FAIL arst_pre: got awvalid %b wvalid %b, expected 1 1", awvalid, wvalid);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({awvalid, wvalid, bready, arvalid, data_sram_data_ok} !== 5'b0 || data_sram_rdata !== 32'd0) begin
            errors++; $display("[TB] FAIL arst_async: got valids %b rdata %h, expected 00000 0",
                               {awvalid, wvalid, bready, arvalid, data_sram_data_ok}, data_sram_rdata);
        end
        model_rdata = 32'd0;
        @(negedge Clk);
        reset = 1'b0; data_sram_req = 1'b0;
        @(negedge Clk);
        run_access(1'b0, SZ_BYTE, 32'h2000_0001, 4'h0, 32'h0, 32'h0000_9900, RESP_OKAY, 0, 0, 0, -1);
        model_rdata = 32'h0000_9900;
        checks++;
        if (timed_out || ok_count !== 1 || ok_cycle !== 3 || ar_hs !== 1 || rdata_at_ok !== model_rdata) begin
            errors++; $display("[TB] FAIL arst_recover: got ok %0d at %0d ar %0d data %h, expected 1 at 3 1 %h",
                               ok_count, ok_cycle, ar_hs, rdata_at_ok, model_rdata);
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = SZ_BYTE;
        data_sram_addr = 32'd0; data_sram_wstrb = 4'd0; data_sram_wdata = 32'd0;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = RESP_OKAY;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = RESP_OKAY;
        model_rdata = 32'd0;
        test_reset();
        test_load_basic();
        test_store_byte();
        test_store_orders();
        test_flush_rd();
        test_bus_err();
        test_flush_idle();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
